// File: rtl/writeback_queue_if.sv
// Writeback queue bus interface.
// Carries the writeback request handshake, the register-file write port,
// the operand read/bypass signals and the occupancy count.
//   slave  : the queue itself (accepts requests, drives the write port)
//   master : the producer / register-file side that drives the queue
interface writeback_queue_if;
  logic        InValid;
  logic        InReady;
  logic [2:0]  InAddress;
  logic [15:0] InData;
  logic        Hold;
  logic        WriteEn;
  logic [2:0]  WriteAddress;
  logic [15:0] WriteData;
  logic [2:0]  ReadAddress1;
  logic [2:0]  ReadAddress2;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [15:0] FwdData1;
  logic [15:0] FwdData2;
  logic [2:0]  Count;

  modport slave (
    input  InValid, InAddress, InData, Hold,
           ReadAddress1, ReadAddress2, ReadData1, ReadData2,
    output InReady, WriteEn, WriteAddress, WriteData,
           FwdData1, FwdData2, Count
  );

  modport master (
    output InValid, InAddress, InData, Hold,
           ReadAddress1, ReadAddress2, ReadData1, ReadData2,
    input  InReady, WriteEn, WriteAddress, WriteData,
           FwdData1, FwdData2, Count
  );
endinterface

// File: rtl/writeback_queue.sv
// Four-entry writeback queue in front of a register-file write port.
// Requests {address, data} are buffered in a circular buffer and drained
// one per cycle in FIFO order whenever Hold is low. Writes to register 0
// are accepted and dropped.
// Optional macro WBQ_BYPASS_EN: forward the youngest queued value for a
// matching operand address onto FwdData1/FwdData2; otherwise FwdDataN is
// the raw register-file read data.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   wbq  : writeback_queue_if.slave (request, write port, bypass, Count)
module writeback_queue (
  input  logic               CLK,
  input  logic               RST,
  writeback_queue_if.slave   wbq
);
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     entry_q [DEPTH];
  wb_entry_t     entry_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          in_ready_c;
  logic          write_en_c;
  logic          push_c;
  wb_entry_t     head_entry_c;

  // Handshake: full queue never accepts, even if it also pops this edge.
  always_comb begin
    in_ready_c   = (count_q < CW'(DEPTH)) && !RST;
    write_en_c   = (count_q != '0) && !wbq.Hold && !RST;
    push_c       = wbq.InValid && in_ready_c && (wbq.InAddress != '0);
    head_entry_c = entry_q[head_q];
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) begin
      entry_d[tail_q] = '{addr: wbq.InAddress, data: wbq.InData};
      tail_d          = PW'(tail_q + PW'(1));
    end
    if (write_en_c) begin
      head_d = PW'(head_q + PW'(1));
    end
    unique case ({push_c, write_en_c})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase
  end

  // Entry contents need no reset: Count = 0 hides them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    entry_q <= entry_d;
  end

  // Write port is driven straight from the head entry, zeroed when empty.
  always_comb begin
    wbq.InReady      = in_ready_c;
    wbq.WriteEn      = write_en_c;
    wbq.Count        = count_q;
    wbq.WriteAddress = (count_q != '0) ? head_entry_c.addr : '0;
    wbq.WriteData    = (count_q != '0) ? head_entry_c.data : '0;
  end

`ifdef WBQ_BYPASS_EN
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    wbq.FwdData1 = wbq.ReadData1;
    wbq.FwdData2 = wbq.ReadData2;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((wbq.ReadAddress1 != '0) &&
            (entry_q[PW'(head_q + PW'(i))].addr == wbq.ReadAddress1)) begin
          wbq.FwdData1 = entry_q[PW'(head_q + PW'(i))].data;
        end
        if ((wbq.ReadAddress2 != '0) &&
            (entry_q[PW'(head_q + PW'(i))].addr == wbq.ReadAddress2)) begin
          wbq.FwdData2 = entry_q[PW'(head_q + PW'(i))].data;
        end
      end
    end
  end
`else
  always_comb begin
    wbq.FwdData1 = wbq.ReadData1;
    wbq.FwdData2 = wbq.ReadData2;
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed stimulus, expected writes pushed
// into a scoreboard queue, a negedge monitor pops and compares every write.
module tb_writeback_queue;
  logic CLK;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  int   writes   = 0;

  logic [18:0] exp_q[$];

  writeback_queue_if wbq ();

  writeback_queue dut (
    .CLK (CLK),
    .RST (RST),
    .wbq (wbq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [2:0] a, input logic [15:0] d, input bit accept);
    wbq.InValid   = 1'b1;
    wbq.InAddress = a;
    wbq.InData    = d;
    if (accept && a != 3'd0) exp_q.push_back({a, d});
  endtask

  task automatic idle();
    wbq.InValid   = 1'b0;
    wbq.InAddress = 3'd0;
    wbq.InData    = 16'd0;
  endtask

  // Monitor: every write about to commit must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RST && wbq.WriteEn === 1'b1) begin
      logic [18:0] e;
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write at %0t",
                 wbq.WriteAddress, wbq.WriteData, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(wbq.WriteAddress), 32'(e[18:16]));
        chk("write_data", 32'(wbq.WriteData), 32'(e[15:0]));
      end
    end
  end

  initial begin
    int w0;
    RST = 1'b1;
    wbq.Hold         = 1'b0;
    wbq.ReadAddress1 = 3'd0;
    wbq.ReadAddress2 = 3'd0;
    wbq.ReadData1    = 16'd0;
    wbq.ReadData2    = 16'd0;
    idle();
    tick();
    tick();
    chk("rst_in_ready", 32'(wbq.InReady), 32'd0);
    chk("rst_write_en", 32'(wbq.WriteEn), 32'd0);
    chk("rst_count", 32'(wbq.Count), 32'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(wbq.InReady), 32'd1);
    chk("post_rst_waddr", 32'(wbq.WriteAddress), 32'd0);
    chk("post_rst_wdata", 32'(wbq.WriteData), 32'd0);

    // Single request through an empty queue: one write, one cycle.
    w0 = writes;
    present(3'd3, 16'h1234, 1'b1);
    tick();
    idle();
    chk("single_count1", 32'(wbq.Count), 32'd1);
    chk("single_write_en", 32'(wbq.WriteEn), 32'd1);
    chk("single_waddr", 32'(wbq.WriteAddress), 32'd3);
    chk("single_wdata", 32'(wbq.WriteData), 32'h1234);
    tick();
    chk("single_count0", 32'(wbq.Count), 32'd0);
    chk("single_write_en_off", 32'(wbq.WriteEn), 32'd0);
    chk("single_write_total", 32'(writes - w0), 32'd1);

    // Register 0 requests are accepted but dropped.
    present(3'd0, 16'hFFFF, 1'b1);
    #1;
    chk("zero_in_ready", 32'(wbq.InReady), 32'd1);
    tick();
    idle();
    chk("zero_count", 32'(wbq.Count), 32'd0);
    chk("zero_write_en", 32'(wbq.WriteEn), 32'd0);

    // Fill under Hold, reject a fifth request, then drain in order.
    wbq.Hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      present(3'(i), 16'(9 + i), 1'b1);
      tick();
    end
    present(3'd5, 16'h000E, 1'b0);
    #1;
    chk("full_count", 32'(wbq.Count), 32'd4);
    chk("full_in_ready", 32'(wbq.InReady), 32'd0);
    chk("full_write_en_hold", 32'(wbq.WriteEn), 32'd0);
    tick();
    idle();
    chk("full_fifth_rejected", 32'(wbq.Count), 32'd4);
    wbq.Hold = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk("drain_count", 32'(wbq.Count), 32'(i));
    end

    // Two writes to the same register: bypass must return the younger one.
    wbq.Hold = 1'b1;
    present(3'd5, 16'h1111, 1'b1);
    tick();
    present(3'd5, 16'h2222, 1'b1);
    tick();
    idle();
    wbq.ReadAddress1 = 3'd5;
    wbq.ReadData1    = 16'h0000;
    wbq.ReadAddress2 = 3'd0;
    wbq.ReadData2    = 16'hBEEF;
    #1;
`ifdef WBQ_BYPASS_EN
    chk("bypass_fwd1", 32'(wbq.FwdData1), 32'h2222);
`else
    chk("bypass_fwd1", 32'(wbq.FwdData1), 32'h0000);
`endif
    chk("bypass_addr0_fwd2", 32'(wbq.FwdData2), 32'hBEEF);
    wbq.ReadAddress1 = 3'd0;
    wbq.Hold = 1'b0;
    tick();
    tick();
    chk("bypass_drained", 32'(wbq.Count), 32'd0);

    // Reset to known pointers, bring Count to 3 with tail at 3, then push+pop.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wbq.Hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      present(3'(i), 16'(16'h00A0 + 16'(i)), 1'b1);
      tick();
    end
    wbq.Hold = 1'b0;
    present(3'd4, 16'h00A4, 1'b1);
    tick();
    idle();
    chk("wrap_count", 32'(wbq.Count), 32'd3);
    chk("wrap_head_addr", 32'(wbq.WriteAddress), 32'd2);
    tick();
    tick();
    tick();
    chk("wrap_drained", 32'(wbq.Count), 32'd0);

    // Reset with two entries queued: they are lost.
    wbq.Hold = 1'b1;
    present(3'd6, 16'h0606, 1'b1);
    tick();
    present(3'd7, 16'h0707, 1'b1);
    tick();
    idle();
    chk("prerst_count", 32'(wbq.Count), 32'd2);
    RST = 1'b1;
    wbq.Hold = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_write_en", 32'(wbq.WriteEn), 32'd0);
    chk("midrst_in_ready", 32'(wbq.InReady), 32'd0);
    tick();
    RST = 1'b0;
    #1;
    chk("postrst_count", 32'(wbq.Count), 32'd0);
    chk("postrst_write_en", 32'(wbq.WriteEn), 32'd0);
    chk("postrst_in_ready", 32'(wbq.InReady), 32'd1);
    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
